// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle MIPS-subset core with a shared ALU, internal imem/dmem and HALT.
// Define MCPU_PERF_CNT_EN to build the cycle/instruction performance counters.
module multicycle_cpu #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int IMEM_AW    = 6,
  parameter int DMEM_DEPTH = 64,
  parameter int DMEM_AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        initialize,
  input  logic [31:0] instruction_initialize_data,
  input  logic [31:0] instruction_initialize_address,
  output logic [31:0] pc_out,
  output logic [2:0]  state_out,
  output logic        retire,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW  = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_J   = 6'h02, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_AND = 6'h24, FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A, FN_JR   = 6'h08;

  state_t            state, next_state;
  logic [31:0]       pc, pc_next, ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr, alu_result;
  logic [DATA_W-1:0] regs [32];
  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic              illegal_q;

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, reg_waddr;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs_val, rt_val, imm_sext, imm_lui, reg_wdata;
  logic [31:0]       br_off;
  logic is_r_alu, is_jr, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_lui, is_halt, is_illegal;
  logic branch_taken;
  logic retire_c, set_illegal, ir_load, ab_load, alu_load, mdr_load, dmem_we, reg_we;
  logic unused_init_addr;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];

  assign rs_val   = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : regs[rt];
  assign imm_sext = DATA_W'($signed(imm));
  // Shift form keeps lui legal down to DATA_W=16, where the zero fill is empty.
  assign imm_lui  = DATA_W'(imm) << (DATA_W - 16);
  assign br_off   = {{14{imm[15]}}, imm, 2'b00};

  assign is_r_alu = (opcode == OP_RTYPE) &&
                    (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                     funct == FN_OR  || funct == FN_SLT);
  assign is_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_j     = (opcode == OP_J);
  assign is_lui   = (opcode == OP_LUI);
  assign is_halt  = (opcode == OP_HALT);
  assign is_illegal = !(is_r_alu || is_jr || is_addi || is_lw || is_sw || is_beq ||
                        is_bne || is_j || is_lui || is_halt);

  assign branch_taken = is_beq ? (a == b) : (a != b);
  assign reg_waddr    = is_r_alu ? rd : rt;
  assign reg_wdata    = is_lw ? mdr : alu_out;

  always_comb begin
    alu_result = a + imm_sext;
    if (is_lui) begin
      alu_result = imm_lui;
    end else if (is_r_alu) begin
      case (funct)
        FN_ADD:  alu_result = a + b;
        FN_SUB:  alu_result = a - b;
        FN_AND:  alu_result = a & b;
        FN_OR:   alu_result = a | b;
        default: alu_result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    pc_next     = pc;
    retire_c    = 1'b0;
    set_illegal = 1'b0;
    ir_load     = 1'b0;
    ab_load     = 1'b0;
    alu_load    = 1'b0;
    mdr_load    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    case (state)
      FETCH: begin
        ir_load    = 1'b1;
        pc_next    = pc + 32'd4;
        next_state = DECODE;
      end
      DECODE: begin
        ab_load = 1'b1;
        if (is_j) begin
          pc_next    = {pc[31:28], ir[25:0], 2'b00};
          retire_c   = 1'b1;
          next_state = FETCH;
        end else if (is_jr) begin
          pc_next    = 32'(rs_val) & 32'hFFFF_FFFC;
          retire_c   = 1'b1;
          next_state = FETCH;
        end else if (is_halt) begin
          next_state = HALT;
        end else if (is_illegal) begin
          set_illegal = 1'b1;
          retire_c    = 1'b1;
          next_state  = FETCH;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        alu_load = 1'b1;
        if (is_beq || is_bne) begin
          if (branch_taken) pc_next = pc + br_off;
          retire_c   = 1'b1;
          next_state = FETCH;
        end else if (is_lw || is_sw) begin
          next_state = MEM;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        if (is_sw) begin
          dmem_we    = 1'b1;
          retire_c   = 1'b1;
          next_state = FETCH;
        end else begin
          mdr_load   = 1'b1;
          next_state = WB;
        end
      end
      WB: begin
        reg_we     = 1'b1;
        retire_c   = 1'b1;
        next_state = FETCH;
      end
      default: ;
    endcase
    // Loading imem overrides whatever the core was doing, including HALT.
    if (initialize) begin
      next_state  = FETCH;
      pc_next     = '0;
      retire_c    = 1'b0;
      set_illegal = 1'b0;
      ir_load     = 1'b0;
      ab_load     = 1'b0;
      alu_load    = 1'b0;
      mdr_load    = 1'b0;
      dmem_we     = 1'b0;
      reg_we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      illegal_q <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= next_state;
      pc    <= pc_next;
      if (ir_load) ir <= imem[pc[IMEM_AW+1:2]];
      if (ab_load) begin
        a <= rs_val;
        b <= rt_val;
      end
      if (alu_load) alu_out <= alu_result;
      if (mdr_load) mdr <= dmem[alu_out[DMEM_AW+1:2]];
      if (reg_we && reg_waddr != 5'd0) regs[reg_waddr] <= reg_wdata;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && initialize)
      imem[instruction_initialize_address[IMEM_AW+1:2]] <= instruction_initialize_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && dmem_we) dmem[alu_out[DMEM_AW+1:2]] <= b;
  end

`ifdef MCPU_PERF_CNT_EN
  logic [31:0] cycle_q, instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (!initialize && state != HALT) cycle_q <= cycle_q + 32'd1;
      if (retire_c) instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

  assign unused_init_addr = ^{instruction_initialize_address[31:IMEM_AW+2],
                              instruction_initialize_address[1:0]};

  assign pc_out    = pc;
  assign state_out = state;
  assign retire    = retire_c & ~rst;
  assign halted    = (state == HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: directed ISA scenarios plus random programs
// compared against an instruction-level reference model.
`timescale 1ns/1ps
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        initialize = 1'b0;
  logic [31:0] init_data = '0;
  logic [31:0] init_addr = '0;
  logic [31:0] pc_out, cycle_count, instr_count;
  logic [2:0]  state_out;
  logic        retire, halted, illegal;

  int checks = 0;
  int errors = 0;

  multicycle_cpu #(
    .DATA_W(32), .IMEM_DEPTH(64), .IMEM_AW(6), .DMEM_DEPTH(64), .DMEM_AW(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .initialize(initialize),
    .instruction_initialize_data(init_data),
    .instruction_initialize_address(init_addr),
    .pc_out(pc_out),
    .state_out(state_out),
    .retire(retire),
    .halted(halted),
    .illegal(illegal),
    .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Reference model state: architectural view only.
  logic [31:0] m_imem [64];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc;
  logic        m_illegal;
  logic [31:0] prog [$];
  int          ret_cyc [$];

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  function automatic logic [31:0] r_op(input int funct, input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(funct)};
  endfunction

  function automatic logic [31:0] i_op(input int op, input int rt, input int rs, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_op(input int target);
    return {6'h02, 26'(target)};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endtask

  task automatic load(input bit do_reset);
    logic [31:0] junk;
    if (do_reset) begin
      rst = 1'b1;
      step();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_illegal = 1'b0;
    end
    rst = 1'b0;
    initialize = 1'b1;
    foreach (prog[i]) begin
      junk      = $urandom();
      init_addr = {junk[31:8], 6'(i), junk[1:0]};
      init_data = prog[i];
      m_imem[i % 64] = prog[i];
      step();
    end
    initialize = 1'b0;
    m_pc = '0;
  endtask

  task automatic run_dut(input int budget, output int cyc, output int nret);
    cyc = 0;
    nret = 0;
    ret_cyc.delete();
    while (!halted && cyc < budget) begin
      if (retire) begin
        nret++;
        ret_cyc.push_back(cyc + 1);
      end
      step();
      cyc++;
    end
  endtask

  task automatic model_run(output int cyc, output int nret);
    logic [31:0] ir, a, b, simm, addr;
    logic [4:0]  rs, rt, rd;
    bit          done;
    int          steps;
    cyc = 0; nret = 0; done = 0; steps = 0;
    while (!done && steps < 5000) begin
      ir   = m_imem[(m_pc >> 2) % 64];
      m_pc = m_pc + 32'd4;
      steps++;
      rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      a  = m_regs[rs]; b = m_regs[rt];
      simm = {{16{ir[15]}}, ir[15:0]};
      addr = a + simm;
      nret++;
      case (ir[31:26])
        6'h00: case (ir[5:0])
          6'h20: begin wr(rd, a + b); cyc += 4; end
          6'h22: begin wr(rd, a - b); cyc += 4; end
          6'h24: begin wr(rd, a & b); cyc += 4; end
          6'h25: begin wr(rd, a | b); cyc += 4; end
          6'h2A: begin wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0); cyc += 4; end
          6'h08: begin m_pc = a & ~32'd3; cyc += 2; end
          default: begin m_illegal = 1'b1; cyc += 2; end
        endcase
        6'h08: begin wr(rt, a + simm); cyc += 4; end
        6'h0F: begin wr(rt, {ir[15:0], 16'h0000}); cyc += 4; end
        6'h23: begin wr(rt, m_dmem[(addr >> 2) % 64]); cyc += 5; end
        6'h2B: begin m_dmem[(addr >> 2) % 64] = b; cyc += 4; end
        6'h04: begin if (a == b) m_pc = m_pc + (simm << 2); cyc += 3; end
        6'h05: begin if (a != b) m_pc = m_pc + (simm << 2); cyc += 3; end
        6'h02: begin m_pc = {m_pc[31:28], ir[25:0], 2'b00}; cyc += 2; end
        6'h3F: begin cyc += 2; nret--; done = 1; end
        default: begin m_illegal = 1'b1; cyc += 2; end
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    initialize = 1'b0;
    repeat (2) step();
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_out); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_out); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL reset_retire got %b want 0", retire); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
  endtask

  // Backward-branch loop that zeroes the whole data memory.
  task automatic test_dmem_clear();
    int ec, er, c, r;
    for (int i = 0; i < 64; i++) m_dmem[i] = 32'hDEAD_BEEF;
    prog = '{i_op(8, 2, 0, 256), i_op(8, 1, 0, 0), i_op(16'h2B, 0, 1, 0),
             i_op(8, 1, 1, 4), i_op(5, 2, 1, -3), HALT_W};
    load(1);
    model_run(ec, er);
    run_dut(2000, c, r);
    checks++; if (c !== ec) begin errors++; $display("FAIL loop_cycles got %0d want %0d", c, ec); end
    checks++; if (r !== er) begin errors++; $display("FAIL loop_retires got %0d want %0d", r, er); end
    checks++; if (dut.regs[1] !== m_regs[1]) begin errors++; $display("FAIL loop_r1 got %h want %h", dut.regs[1], m_regs[1]); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (dut.dmem[i] !== m_dmem[i]) begin errors++; $display("FAIL loop_dmem[%0d] got %h want %h", i, dut.dmem[i], m_dmem[i]); end
    end
  endtask

  task automatic test_arith();
    int c, r;
    prog = '{i_op(8, 1, 0, 5), i_op(8, 2, 0, -3), r_op(32, 3, 1, 2), HALT_W};
    load(1);
    run_dut(100, c, r);
    checks++; if (dut.regs[3] !== 32'd2) begin errors++; $display("FAIL arith_r3 got %h want 2", dut.regs[3]); end
    checks++; if (c !== 14) begin errors++; $display("FAIL arith_cycles got %0d want 14", c); end
    checks++; if (r !== 3) begin errors++; $display("FAIL arith_retires got %0d want 3", r); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL arith_halted got %b want 1", halted); end
`ifdef MCPU_PERF_CNT_EN
    checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL perf_instr got %0d want 3", instr_count); end
    checks++; if (cycle_count !== 32'd14) begin errors++; $display("FAIL perf_cycle got %0d want 14", cycle_count); end
`else
    checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL perf_instr_tied got %0d want 0", instr_count); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL perf_cycle_tied got %0d want 0", cycle_count); end
`endif
    // HALT must hold everything still.
    repeat (5) step();
    checks++; if (pc_out !== 32'd16) begin errors++; $display("FAIL halt_hold_pc got %h want 10", pc_out); end
  endtask

  task automatic test_mem();
    int c, r, gap;
    prog = '{i_op(8, 3, 0, 16'h1234), i_op(16'h2B, 3, 0, 8), i_op(16'h23, 4, 0, 8), HALT_W};
    load(1);
    run_dut(100, c, r);
    gap = (ret_cyc.size() >= 3) ? ret_cyc[2] - ret_cyc[1] : -1;
    checks++; if (dut.dmem[2] !== 32'h1234) begin errors++; $display("FAIL mem_dmem2 got %h want 1234", dut.dmem[2]); end
    checks++; if (dut.regs[4] !== 32'h1234) begin errors++; $display("FAIL mem_r4 got %h want 1234", dut.regs[4]); end
    checks++; if (gap !== 5) begin errors++; $display("FAIL mem_lw_retire_cycle got %0d want 5", gap); end
    checks++; if (c !== 15) begin errors++; $display("FAIL mem_cycles got %0d want 15", c); end
    m_dmem[2] = 32'h1234;
  endtask

  task automatic test_branch_jump();
    logic [31:0] p0 [4];
    logic [31:0] p1 [4];
    int          edges [4];
    logic [31:0] want [4];
    p0 = '{i_op(4, 1, 1, 2), i_op(5, 1, 1, 2), j_op(16'h10), i_op(8, 5, 0, 16'h23)};
    p1 = '{HALT_W, HALT_W, HALT_W, r_op(8, 0, 5, 0)};
    edges = '{3, 3, 2, 6};
    want  = '{32'd12, 32'd4, 32'h40, 32'h20};
    for (int s = 0; s < 4; s++) begin
      prog = '{p0[s], p1[s]};
      load(1);
      repeat (edges[s]) step();
      checks++; if (pc_out !== want[s]) begin errors++; $display("FAIL branch_pc[%0d] got %h want %h", s, pc_out, want[s]); end
      checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL branch_state[%0d] got %0d want 0", s, state_out); end
    end
  endtask

  task automatic test_lui_r0_illegal();
    int c, r;
    prog = '{i_op(16'h0F, 6, 0, 16'hABCD), i_op(8, 0, 0, 7), 32'hF800_0000, HALT_W};
    load(1);
    repeat (8) step();
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_early got %b want 0", illegal); end
    repeat (2) step();
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b want 1", illegal); end
    checks++; if (pc_out !== 32'd12) begin errors++; $display("FAIL illegal_pc got %h want c", pc_out); end
    run_dut(50, c, r);
    checks++; if (c !== 2) begin errors++; $display("FAIL illegal_halt_cycles got %0d want 2", c); end
    checks++; if (dut.regs[6] !== 32'hABCD_0000) begin errors++; $display("FAIL lui_r6 got %h want abcd0000", dut.regs[6]); end
    checks++; if (dut.regs[0] !== 32'd0) begin errors++; $display("FAIL r0_write got %h want 0", dut.regs[0]); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %b want 1", illegal); end
  endtask

  task automatic test_reset_mid_wb();
    prog = '{i_op(8, 1, 0, 5), i_op(8, 2, 0, -3), r_op(32, 3, 1, 2), HALT_W};
    load(1);
    repeat (11) step();
    checks++; if (state_out !== 3'd4) begin errors++; $display("FAIL midwb_state got %0d want 4", state_out); end
    rst = 1'b1;
    #1;
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL midwb_retire got %b want 0", retire); end
    step();
    rst = 1'b0;
    checks++; if (dut.regs[3] !== 32'd0) begin errors++; $display("FAIL midwb_r3 got %h want 0", dut.regs[3]); end
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL midwb_pc got %h want 0", pc_out); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL midwb_state_after got %0d want 0", state_out); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_init_halt();
    int ec, er, c, r;
    prog = '{i_op(8, 1, 0, 5), i_op(8, 2, 0, -3), r_op(32, 3, 1, 2), HALT_W};
    load(1);
    model_run(ec, er);
    run_dut(100, c, r);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL inithalt_halted got %b want 1", halted); end
    initialize = 1'b1;
    init_addr  = 32'd0;
    init_data  = i_op(8, 7, 0, 9);
    step();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL inithalt_release got %b want 0", halted); end
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL inithalt_pc got %h want 0", pc_out); end
    prog = '{i_op(8, 7, 0, 9), HALT_W};
    load(0);
    model_run(ec, er);
    run_dut(100, c, r);
    checks++; if (c !== ec) begin errors++; $display("FAIL inithalt_cycles got %0d want %0d", c, ec); end
    checks++; if (dut.regs[7] !== m_regs[7]) begin errors++; $display("FAIL inithalt_r7 got %h want %h", dut.regs[7], m_regs[7]); end
    checks++; if (dut.regs[3] !== m_regs[3]) begin errors++; $display("FAIL inithalt_r3 got %h want %h", dut.regs[3], m_regs[3]); end
`ifdef MCPU_PERF_CNT_EN
    checks++; if (instr_count !== 32'd4) begin errors++; $display("FAIL inithalt_instr got %0d want 4", instr_count); end
    checks++; if (cycle_count !== 32'd20) begin errors++; $display("FAIL inithalt_cycle got %0d want 20", cycle_count); end
`endif
  endtask

  task automatic test_random();
    int fl [5];
    int n, sel, k, ec, er, c, r;
    fl = '{32, 34, 36, 37, 42};
    for (int t = 0; t < 8; t++) begin
      n = 10 + int'($urandom_range(0, 7));
      prog.delete();
      for (int i = 0; i < n; i++) begin
        sel = int'($urandom_range(0, 9));
        case (sel)
          5: prog.push_back(i_op(8, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
          6: prog.push_back(i_op(16'h0F, $urandom_range(1, 7), 0, $urandom_range(0, 65535)));
          7: prog.push_back(i_op(16'h2B, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
          8: prog.push_back(i_op(16'h23, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
          9: begin
            k = int'($urandom_range(0, (n - 1 - i) < 2 ? (n - 1 - i) : 2));
            prog.push_back(i_op($urandom_range(4, 5), $urandom_range(0, 7), $urandom_range(0, 7), k));
          end
          default: prog.push_back(r_op(fl[$urandom_range(0, 4)], $urandom_range(0, 7),
                                       $urandom_range(0, 7), $urandom_range(0, 7)));
        endcase
      end
      prog.push_back(HALT_W);
      load(1);
      model_run(ec, er);
      run_dut(1000, c, r);
      checks++; if (c !== ec) begin errors++; $display("FAIL rand%0d_cycles got %0d want %0d", t, c, ec); end
      checks++; if (r !== er) begin errors++; $display("FAIL rand%0d_retires got %0d want %0d", t, r, er); end
      checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL rand%0d_pc got %h want %h", t, pc_out, m_pc); end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (dut.regs[i] !== m_regs[i]) begin errors++; $display("FAIL rand%0d_r%0d got %h want %h", t, i, dut.regs[i], m_regs[i]); end
      end
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (dut.dmem[i] !== m_dmem[i]) begin errors++; $display("FAIL rand%0d_dmem[%0d] got %h want %h", t, i, dut.dmem[i], m_dmem[i]); end
      end
    end
  endtask

  initial begin
    m_pc = '0;
    m_illegal = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < 64; i++) m_imem[i] = '0;
    for (int i = 0; i < 64; i++) m_dmem[i] = '0;
    test_reset();
    test_dmem_clear();
    test_arith();
    test_mem();
    test_branch_jump();
    test_lui_r0_illegal();
    test_reset_mid_wb();
    test_init_halt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
